// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB-to-UART bridge: register map, FSM states
// and the request kinds produced by the address decoder.
package apb_uart_pkg;

    localparam logic [31:0] ADDR_TRANS_DATA = 32'h0000_0000;
    localparam logic [31:0] ADDR_RECV_DATA  = 32'h0000_0004;
    localparam logic [31:0] ADDR_BAUD_CFG   = 32'h0000_0008;
    localparam logic [31:0] ADDR_FRAME_CFG  = 32'h0000_000C;
    localparam logic [31:0] ADDR_PARITY_CFG = 32'h0000_0010;
    localparam logic [31:0] ADDR_STOP_CFG   = 32'h0000_0014;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_TX,
        REQ_RX,
        REQ_CFG_WR,
        REQ_CFG_RD
    } req_e;

endpackage

// File: rtl/apb_uart_addr_decode.sv
// Maps an APB address plus direction onto the UART request it triggers;
// REQ_NONE means the access is unmapped and must be answered with an error.
module apb_uart_addr_decode
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output req_e                  req
);

    always_comb begin
        req = REQ_NONE;
        case (addr)
            ADDR_WIDTH'(ADDR_TRANS_DATA): req = write ? REQ_TX : REQ_NONE;
            ADDR_WIDTH'(ADDR_RECV_DATA):  req = write ? REQ_NONE : REQ_RX;
            ADDR_WIDTH'(ADDR_BAUD_CFG),
            ADDR_WIDTH'(ADDR_FRAME_CFG),
            ADDR_WIDTH'(ADDR_PARITY_CFG),
            ADDR_WIDTH'(ADDR_STOP_CFG):   req = write ? REQ_CFG_WR : REQ_CFG_RD;
            default:                      req = REQ_NONE;
        endcase
    end

endmodule

// File: rtl/apb_uart_bridge.sv
// APB slave that turns each transfer into a single UART request pulse and
// waits (with timeout) for the UART side to answer before completing.
module apb_uart_bridge
    import apb_uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  tx_req,
    output logic                  rx_req,
    output logic                  cfg_wr_req,
    output logic                  cfg_rd_req,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  uart_ready,
    input  logic                  uart_error,
    input  logic [DATA_WIDTH-1:0] uart_rdata,
    output logic                  timeout_pulse
);

    state_e                  state_q, state_d;
    req_e                    dec_req;
    logic [7:0]              cnt_q;
    logic                    write_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    setup_hit;
    logic                    ready_hit;
    logic                    tout_hit;

    apb_uart_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .addr  (PADDR),
        .write (PWRITE),
        .req   (dec_req)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Abort has priority over completion: a deselected master gets nothing back.
    always_comb begin
        state_d   = state_q;
        setup_hit = 1'b0;
        ready_hit = 1'b0;
        tout_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    setup_hit = 1'b1;
                    state_d   = (dec_req == REQ_NONE) ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!PSELx) begin
                    state_d = ST_IDLE;
                end else if (uart_ready) begin
                    ready_hit = 1'b1;
                    state_d   = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    tout_hit = 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q         <= '0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            cfg_addr      <= '0;
            wr_data       <= '0;
            tx_req        <= 1'b0;
            rx_req        <= 1'b0;
            cfg_wr_req    <= 1'b0;
            cfg_rd_req    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            tx_req        <= 1'b0;
            rx_req        <= 1'b0;
            cfg_wr_req    <= 1'b0;
            cfg_rd_req    <= 1'b0;
            timeout_pulse <= tout_hit;
            // cnt_q holds the number of ACCESS cycles already completed
            cnt_q <= (state_q == ST_ACCESS && state_d == ST_ACCESS) ? cnt_q + 8'd1 : 8'd0;
            if (setup_hit) begin
                cfg_addr   <= PADDR;
                wr_data    <= PWDATA;
                write_q    <= PWRITE;
                err_q      <= (dec_req == REQ_NONE);
                rdata_q    <= '0;
                tx_req     <= (dec_req == REQ_TX);
                rx_req     <= (dec_req == REQ_RX);
                cfg_wr_req <= (dec_req == REQ_CFG_WR);
                cfg_rd_req <= (dec_req == REQ_CFG_RD);
            end
            if (ready_hit) begin
                err_q   <= uart_error;
                rdata_q <= write_q ? '0 : uart_rdata;
            end
            if (tout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign PREADY  = (state_q == ST_RESP);
    assign PSLVERR = PREADY & err_q;
    assign PRDATA  = (PREADY && !err_q && !write_q) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed and randomized APB transfers against a transaction-level model of
// the bridge's response timing, error and read-data rules.
module tb_apb_uart_bridge;
    import apb_uart_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          PSELx, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic          tx_req, rx_req, cfg_wr_req, cfg_rd_req;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] wr_data;
    logic          uart_ready, uart_error;
    logic [DW-1:0] uart_rdata;
    logic          timeout_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    apb_uart_bridge #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .PSELx         (PSELx),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .tx_req        (tx_req),
        .rx_req        (rx_req),
        .cfg_wr_req    (cfg_wr_req),
        .cfg_rd_req    (cfg_rd_req),
        .cfg_addr      (cfg_addr),
        .wr_data       (wr_data),
        .uart_ready    (uart_ready),
        .uart_error    (uart_error),
        .uart_rdata    (uart_rdata),
        .timeout_pulse (timeout_pulse)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected request as {tx, rx, cfg_wr, cfg_rd}; zero means unmapped.
    function automatic logic [3:0] model_req(input logic [31:0] a, input logic w);
        if (a == ADDR_TRANS_DATA) return w ? 4'b1000 : 4'b0000;
        if (a == ADDR_RECV_DATA)  return w ? 4'b0000 : 4'b0100;
        if (a == ADDR_BAUD_CFG || a == ADDR_FRAME_CFG ||
            a == ADDR_PARITY_CFG || a == ADDR_STOP_CFG)
            return w ? 4'b0010 : 4'b0001;
        return 4'b0000;
    endfunction

    function automatic logic activity();
        return PREADY | PSLVERR | timeout_pulse | tx_req | rx_req |
               cfg_wr_req | cfg_rd_req | (PRDATA != '0);
    endfunction

    // Called #1 after a posedge; returns #1 after a posedge with the bus idle.
    // d = number of ACCESS cycles the UART stays busy before raising ready.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int d, input logic uerr,
                        input logic [31:0] rd);
        logic [3:0]  exp_req, first, stray, pulses;
        int          exp_k, got_k;
        logic        exp_err, exp_to, got_err, got_to, bad;
        logic [31:0] exp_rd, got_rd, lat_a, lat_w;
        exp_req = model_req(addr, wr);
        if (exp_req == 4'b0000) begin
            exp_k = 1; exp_err = 1'b1; exp_to = 1'b0;
        end else if (d + 1 <= TO) begin
            exp_k = d + 2; exp_err = uerr; exp_to = 1'b0;
        end else begin
            exp_k = TO + 1; exp_err = 1'b1; exp_to = 1'b1;
        end
        exp_rd = (!wr && !exp_err) ? rd : 32'h0;
        got_k = 0; got_err = 1'b0; got_to = 1'b0; got_rd = '0;
        first = '0; stray = '0; lat_a = '0; lat_w = '0;

        PSELx = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd;
        uart_ready = 1'b0;
        @(negedge PCLK);
        bad = activity();
        for (int k = 1; k <= TO + 4 && got_k == 0; k++) begin
            @(posedge PCLK); #1;
            PENABLE = 1'b1;
            uart_ready = (k == d + 1);
            uart_error = uerr;
            uart_rdata = rd;
            @(negedge PCLK);
            pulses = {tx_req, rx_req, cfg_wr_req, cfg_rd_req};
            if (k == 1) begin
                first = pulses; lat_a = cfg_addr; lat_w = wr_data;
            end else begin
                stray |= pulses;
            end
            if (PREADY) begin
                got_k = k; got_err = PSLVERR; got_rd = PRDATA; got_to = timeout_pulse;
            end else if (PSLVERR || PRDATA != '0 || timeout_pulse) begin
                bad = 1'b1;
            end
        end
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; uart_ready = 1'b0;

        chk({tag, ".latency"},  64'(got_k),   64'(exp_k));
        chk({tag, ".pslverr"},  64'(got_err), 64'(exp_err));
        chk({tag, ".prdata"},   64'(got_rd),  64'(exp_rd));
        chk({tag, ".timeout"},  64'(got_to),  64'(exp_to));
        chk({tag, ".req"},      64'(first),   64'(exp_req));
        chk({tag, ".stray"},    64'(stray),   64'(0));
        chk({tag, ".idle_out"}, 64'(bad),     64'(0));
        chk({tag, ".cfg_addr"}, 64'(lat_a),   64'(addr));
        chk({tag, ".wr_data"},  64'(lat_w),   64'(wd));
    endtask

    task automatic watch(input string tag, input int n);
        logic q;
        q = 1'b0;
        repeat (n) begin
            @(negedge PCLK);
            q |= activity();
            @(posedge PCLK); #1;
        end
        chk(tag, 64'(q), 64'(0));
    endtask

    initial begin
        logic [31:0] map [6];
        logic [31:0] a;
        map = '{ADDR_TRANS_DATA, ADDR_RECV_DATA, ADDR_BAUD_CFG,
                ADDR_FRAME_CFG, ADDR_PARITY_CFG, ADDR_STOP_CFG};

        PRESETn = 1'b0; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; uart_ready = 1'b0; uart_error = 1'b0; uart_rdata = '0;
        #2;
        chk("reset.ctl", 64'({PREADY, PSLVERR, timeout_pulse, tx_req, rx_req,
                              cfg_wr_req, cfg_rd_req, PRDATA}), 64'(0));
        chk("reset.cfg_addr", 64'(cfg_addr), 64'(0));
        chk("reset.wr_data",  64'(wr_data),  64'(0));
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Setup lands in the very first clock after reset release.
        xfer("tx_a5", ADDR_TRANS_DATA, 1'b1, 32'hA5, 0, 1'b0, 32'h0);
        xfer("rx_3c", ADDR_RECV_DATA, 1'b0, 32'h0, 2, 1'b0, 32'h3C);
        xfer("unmapped_rd", 32'h0000_0100, 1'b0, 32'h0, 0, 1'b0, 32'h55);
        xfer("rd_trans", ADDR_TRANS_DATA, 1'b0, 32'h0, 0, 1'b0, 32'h77);
        xfer("wr_recv", ADDR_RECV_DATA, 1'b1, 32'h12, 0, 1'b0, 32'h0);
        xfer("timeout", ADDR_FRAME_CFG, 1'b0, 32'h0, 20, 1'b0, 32'h99);
        xfer("after_to", ADDR_FRAME_CFG, 1'b0, 32'h0, 1, 1'b0, 32'h1234);
        xfer("tie_err", ADDR_PARITY_CFG, 1'b0, 32'h0, TO - 1, 1'b1, 32'hBEEF);
        xfer("tie_ok", ADDR_STOP_CFG, 1'b0, 32'h0, TO - 1, 1'b0, 32'hCAFE);
        xfer("cfg_wr_err", ADDR_BAUD_CFG, 1'b1, 32'h1C200, 0, 1'b1, 32'h0);

        // Reset in the second ACCESS cycle discards the transfer.
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = ADDR_BAUD_CFG; PWRITE = 1'b1; PWDATA = 32'h3;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PRESETn = 1'b0;
        #1;
        chk("midrst.ctl", 64'({PREADY, PSLVERR, timeout_pulse, tx_req, rx_req,
                               cfg_wr_req, cfg_rd_req, PRDATA}), 64'(0));
        chk("midrst.cfg_addr", 64'(cfg_addr), 64'(0));
        chk("midrst.wr_data",  64'(wr_data),  64'(0));
        uart_ready = 1'b1;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; uart_ready = 1'b0; PRESETn = 1'b1;
        watch("midrst.quiet", 4);
        xfer("post_rst", ADDR_BAUD_CFG, 1'b1, 32'h2580, 1, 1'b0, 32'h0);

        // Deselect during ACCESS aborts; a later long wait must not time out early.
        PSELx = 1'b1; PENABLE = 1'b0; PADDR = ADDR_BAUD_CFG; PWRITE = 1'b0;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #1 PSELx = 1'b0; PENABLE = 1'b0;
        watch("abort.quiet", 4);
        xfer("post_abort", ADDR_BAUD_CFG, 1'b0, 32'h0, TO - 1, 1'b0, 32'h4B0);

        // PENABLE without a setup phase is ignored.
        PSELx = 1'b1; PENABLE = 1'b1; PADDR = ADDR_TRANS_DATA; PWRITE = 1'b1; PWDATA = 32'h66;
        watch("noset.quiet", 3);
        PSELx = 1'b0; PENABLE = 1'b0;
        xfer("post_noset", ADDR_TRANS_DATA, 1'b1, 32'h67, 0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel < 6) a = map[sel];
            else a = 32'h18 + 32'($urandom_range(0, 100)) * 32'd4;
            xfer($sformatf("rnd%0d", i), a, 1'($urandom_range(0, 1)), $urandom,
                 int'($urandom_range(0, TO + 1)), ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 2) == 0) @(posedge PCLK);
            #0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_uart_bridge.md
APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: APB and UART data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: APB address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum ACCESS cycles before timeout, range 1..255.
REQ-004 SHALL have ports PCLK in 1 (sole clock); PRESETn in 1 (asynchronous active-low reset).
REQ-005 SHALL have APB inputs PSELx 1, PENABLE 1, PWRITE 1, PADDR ADDR_WIDTH, PWDATA DATA_WIDTH.
REQ-006 SHALL have APB outputs PRDATA DATA_WIDTH, PREADY 1, PSLVERR 1.
REQ-007 SHALL have UART request outputs tx_req 1, rx_req 1, cfg_wr_req 1, cfg_rd_req 1; each is a one-cycle pulse.
REQ-008 SHALL have UART outputs cfg_addr ADDR_WIDTH and wr_data DATA_WIDTH, both latched.
REQ-009 SHALL have UART inputs uart_ready 1, uart_error 1, uart_rdata DATA_WIDTH.
REQ-010 SHALL have output timeout_pulse 1: high for one cycle when a transfer times out.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-012 In IDLE, PSELx=1 with PENABLE=0 (setup) SHALL latch PADDR, PWRITE and PWDATA into cfg_addr, an internal write flag and wr_data.
REQ-013 A setup to a mapped address SHALL go to ACCESS; a setup to an unmapped address SHALL go directly to RESP with an error flagged.
REQ-014 Mapped addresses: trans_data is write-only (tx_req); recv_data is read-only (rx_req); baud, frame, parity and stop_bits config are read/write (cfg_wr_req/cfg_rd_req).
REQ-015 A write to recv_data or a read of trans_data SHALL be treated as unmapped.
REQ-016 Exactly one request pulse SHALL be asserted, registered, in the first ACCESS cycle only.
REQ-017 In ACCESS, the first cycle with uart_ready=1 SHALL capture uart_error, and uart_rdata for reads, then go to RESP.
REQ-018 In ACCESS, a cycle counter SHALL increment each cycle; reaching TIMEOUT_CYCLES without uart_ready SHALL go to RESP with the error flagged and timeout_pulse=1.
REQ-019 If uart_ready and timeout occur in the same cycle, uart_ready SHALL win and no timeout SHALL be flagged.
REQ-020 In RESP (one cycle), PREADY=1 and PSLVERR=captured error; PRDATA=captured data for reads, 0 for writes and on any error; next state IDLE.
REQ-021 Outside RESP, PREADY=0, PSLVERR=0 and PRDATA=0.
REQ-022 PSELx=0 while in ACCESS SHALL abort to IDLE: no PREADY, counter cleared, no further requests.
REQ-023 PENABLE=1 seen in IDLE without a preceding setup SHALL be ignored.
REQ-024 Minimum latency: setup at cycle T, request at T+1, PREADY at T+2 if uart_ready is high at T+1.
REQ-025 Unmapped accesses SHALL give PREADY at T+1 and SHALL issue no request.
REQ-026 Back-to-back transfers: a setup in the cycle after RESP SHALL be accepted normally.

Reset
REQ-027 PRESETn=0 SHALL asynchronously force state IDLE, counter 0, all request pulses 0, PREADY/PSLVERR/PRDATA/timeout_pulse 0, cfg_addr and wr_data 0.
REQ-028 Reset mid-transfer SHALL discard the transfer; no response SHALL be produced after reset release.
REQ-029 The first setup SHALL be accepted in the first clock after PRESETn deasserts.

Structure
REQ-030 Package apb_uart_pkg SHALL hold the address constants (trans_data, recv_data, baud/frame/parity/stop_bits config) and the FSM state enum.
REQ-031 Sub-module apb_uart_addr_decode (combinational: address plus write flag to request type or unmapped) SHALL be instantiated once.

Verification
REQ-032 Write 0xA5 to trans_data, uart_ready at T+1 -> tx_req one pulse at T+1, wr_data=0xA5, PREADY at T+2, PSLVERR=0.
REQ-033 Read recv_data, uart_ready after 3 ACCESS cycles with rdata 0x3C -> rx_req one pulse, PRDATA=0x3C during the PREADY cycle only.
REQ-034 Read of an unmapped address -> PREADY and PSLVERR at T+1, PRDATA=0, no request pulse.
REQ-035 TIMEOUT_CYCLES=4, uart_ready never asserted -> timeout_pulse and PSLVERR with PREADY after 4 ACCESS cycles; the next transfer completes normally.
REQ-036 uart_ready and the timeout in the same cycle -> PSLVERR=uart_error, no timeout_pulse.
REQ-037 PRESETn low in the second ACCESS cycle -> all outputs 0 immediately, no PREADY after release, next write to baud_config succeeds.
